light_pwm_driver: RTL
=====================

# light_pwm_driver

Output-side driver for the light controller. It takes the 2-bit light level code produced by the light FSM and drives a single LED pin with PWM. Level changes are smooth linear fades, not steps, and duty updates are glitch-free at PWM period boundaries. It sits between the FSM's `o_light` output and the board LED pin, mirroring the debounced button path on the input side.

## Interface
- `PWM_BITS`, default 8: PWM resolution. Period is 2^PWM_BITS−1 clocks.
- `TICK_DIV`, default 100000: clocks per fade step, must be ≥ 2.
- `i_clk` input 1: system clock.
- `i_reset` input 1: reset, asynchronous, active-low.
- `i_light` input 2: requested level code.
  - 00 = off, target 0.
  - 01 = low, target 2^(PWM_BITS−2).
  - 10 = mid, target 2^(PWM_BITS−1).
  - 11 = full, target 2^PWM_BITS−1.
- `o_led` output 1: PWM LED drive, registered.
- `o_duty` output PWM_BITS: current working duty.
- `o_busy` output 1: high while fading (state ≠ IDLE).

## Operation
- Input register: `i_light` is registered every clock. The target is decoded from the registered code, giving 1 cycle input latency.
- FSM states: IDLE, FADE_UP, FADE_DOWN.
  - IDLE → FADE_UP when target > duty.
  - IDLE → FADE_DOWN when target < duty.
  - Otherwise the FSM stays in IDLE.
  - FADE_UP: on each step tick, duty += 1. When the new duty equals the target, go to IDLE.
  - FADE_DOWN: on each step tick, duty −= 1. When the new duty equals the target, go to IDLE.
  - If the target crosses to the other side of duty mid-fade, switch directly to the opposite fade state. The prescaler keeps running.
  - If the target equals duty mid-fade with no tick pending, go to IDLE.
- Step prescaler:
  - Held at 0 while in IDLE.
  - In FADE states it counts 0..TICK_DIV−1. The step tick fires when it reaches TICK_DIV−1, then wraps to 0.
  - The first step therefore lands exactly TICK_DIV clocks after entering a fade state.
- Duty arithmetic:
  - Unsigned, PWM_BITS wide.
  - It never wraps: steps occur only toward the target, so duty stays within 0..2^PWM_BITS−1.
- PWM counter `cnt`:
  - Counts 0..2^PWM_BITS−2, then wraps to 0.
  - Free-running from reset, independent of the FSM.
- Shadow duty:
  - Loaded from duty when `cnt` = 2^PWM_BITS−2, i.e. the last count of the period.
  - Takes effect from `cnt` = 0, so a period never mixes two duty values.
- `o_led` is registered as (cnt < shadow) on the following edge.
  - shadow = 0 gives constant 0.
  - shadow = 2^PWM_BITS−1 gives constant 1.
- `o_duty` reflects the working duty register, not the shadow.

## Timing
- Reset (`i_reset` = 0, asynchronous) forces the following. Everything restarts from 0 on the first edge after release:
  - `o_led` = 0, `o_duty` = 0, `o_busy` = 0.
  - State IDLE; `cnt`, prescaler, shadow and input register all 0.
- Reset mid-fade: the fade is abandoned immediately. After release, the driver re-fades from 0 toward the current `i_light`.
- Request-to-busy latency:
  - Edge 1 registers `i_light`.
  - Edge 2 enters the FADE state; `o_busy` is high after edge 2.
- Full fade time for a distance D, from entering the FADE state: D·TICK_DIV clocks. `o_busy` drops on the same edge that writes the final step.
- Duty-to-pin latency:
  - Wait until the next `cnt` = 2^PWM_BITS−2, when the shadow loads.
  - The new duty is visible on `o_led` one edge after `cnt` = 0.
- Simultaneous step tick and shadow load on the same edge: the shadow takes the pre-step duty. The new step appears in the next period.
- Glitches on `i_light` shorter than the prescaler interval only retarget the fade. There is no debounce; upstream codes are already clean.

## Test plan
- Test parameters: PWM_BITS = 8, TICK_DIV = 4.
- Reset and idle: hold `i_reset` = 0, then release with `i_light` = 00. Required: `o_led` = 0, `o_duty` = 0 and `o_busy` = 0 for 2000 cycles; `cnt` wraps every 255 clocks.
- Fade up to full: `i_light` = 11 from duty 0. Required:
  - `o_busy` rises 2 cycles after the input change.
  - `o_duty` increments every 4 clocks and reaches 255 exactly 1020 clocks after `o_busy` rises.
  - `o_busy` falls on that edge.
  - After the next shadow load, `o_led` is constantly 1.
- PWM accuracy: from steady duty 64 (`i_light` = 01), measure one period. Required: `o_led` high for exactly 64 of 255 clocks, contiguous from `cnt` = 0.
- Mid-fade reversal: from 0, set `i_light` = 10, then at `o_duty` = 40 switch to 01. Required: `o_duty` continues up to 64 and stops (`o_busy` = 0). Then set 00: `o_duty` falls to 0 in 256 clocks with no overshoot.
- Reset mid-fade: assert `i_reset` at `o_duty` = 100 while fading to 255. Required: all outputs 0 asynchronously, before the next edge. After release, the fade restarts from 0.
- Shadow boundary: arrange a step tick on the edge where `cnt` = 254. Required: the next period uses the pre-step duty and the following period uses the stepped duty.

Source files
------------

// File: rtl/light_pwm_driver.sv
`default_nettype none
// ============================================================================
// Module   : light_pwm_driver
// Purpose  : Drives one LED pin with PWM from the light FSM's 2-bit level
//            code. Level changes fade linearly, one duty step per prescaler
//            tick. The duty value seen by the pin is updated only at PWM period
//            boundaries, so a single period never mixes two duty values.
// Ports    : i_clk    - system clock
//            i_reset  - asynchronous, active-low reset
//            i_light  - requested level code (00 off, 01 low, 10 mid, 11 full)
//            o_led    - registered PWM drive for the LED pin
//            o_duty   - working duty register (not the period shadow)
//            o_busy   - high while a fade is in progress
// Params   : PWM_BITS - PWM resolution (>= 3); period is 2^PWM_BITS-1 clocks
//            TICK_DIV - clocks per fade step (>= 2)
// Revision : 1.0 - initial release
// ============================================================================
module light_pwm_driver #(
  parameter int PWM_BITS = 8,
  parameter int TICK_DIV = 100000
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [1:0]          i_light,
  output logic                o_led,
  output logic [PWM_BITS-1:0] o_duty,
  output logic                o_busy
);

  localparam int PRESC_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  localparam logic [PRESC_W-1:0]  C_TICK_LAST = PRESC_W'(TICK_DIV - 1);
  // Last PWM count is 2^PWM_BITS-2, so a full-scale duty keeps the pin high.
  localparam logic [PWM_BITS-1:0] C_CNT_LAST  = {{(PWM_BITS-1){1'b1}}, 1'b0};
  localparam logic [PWM_BITS-1:0] C_TGT_OFF   = '0;
  localparam logic [PWM_BITS-1:0] C_TGT_LOW   = {2'b01, {(PWM_BITS-2){1'b0}}};
  localparam logic [PWM_BITS-1:0] C_TGT_MID   = {2'b10, {(PWM_BITS-2){1'b0}}};
  localparam logic [PWM_BITS-1:0] C_TGT_FULL  = '1;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_FADE_UP   = 2'd1,
    ST_FADE_DOWN = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          light_q, light_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic [PWM_BITS-1:0] cnt_q, cnt_d;
  logic [PWM_BITS-1:0] shadow_q, shadow_d;
  logic                led_q, led_d;

  logic [PWM_BITS-1:0] target;
  logic [PWM_BITS-1:0] step_duty;
  logic                go_up;
  logic                tick;
  logic                period_end;

  // --------------------------------------------------------------------------
  // Input register and target decode (one cycle of input latency)
  // --------------------------------------------------------------------------
  always_comb begin
    light_d = i_light;
  end

  always_comb begin
    target = C_TGT_OFF;
    case (light_q)
      2'b00:   target = C_TGT_OFF;
      2'b01:   target = C_TGT_LOW;
      2'b10:   target = C_TGT_MID;
      default: target = C_TGT_FULL;
    endcase
  end

  // --------------------------------------------------------------------------
  // Fade FSM and step prescaler
  // --------------------------------------------------------------------------
  always_comb begin
    tick      = (presc_q == C_TICK_LAST);
    go_up     = (target > duty_q);
    // Steps only ever move toward the target, so this cannot wrap.
    step_duty = go_up ? (duty_q + 1'b1) : (duty_q - 1'b1);
  end

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    presc_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (target > duty_q) begin
          state_d = ST_FADE_UP;
        end else if (target < duty_q) begin
          state_d = ST_FADE_DOWN;
        end
      end
      ST_FADE_UP, ST_FADE_DOWN: begin
        if (target == duty_q) begin
          // Target moved onto the current duty: nothing left to fade.
          state_d = ST_IDLE;
        end else begin
          // Direction follows the live target, so a mid-fade crossing
          // reverses without restarting the prescaler.
          state_d = go_up ? ST_FADE_UP : ST_FADE_DOWN;
          if (tick) begin
            duty_d = step_duty;
            if (step_duty == target) begin
              state_d = ST_IDLE;
            end
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // PWM counter, period shadow and pin driver
  // --------------------------------------------------------------------------
  always_comb begin
    period_end = (cnt_q == C_CNT_LAST);
    cnt_d      = period_end ? '0 : (cnt_q + 1'b1);
    // The shadow samples the pre-step duty when a tick lands on the same edge.
    shadow_d   = period_end ? duty_q : shadow_q;
    led_d      = (cnt_q < shadow_q);
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q  <= ST_IDLE;
      light_q  <= 2'b00;
      duty_q   <= '0;
      presc_q  <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      led_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      light_q  <= light_d;
      duty_q   <= duty_d;
      presc_q  <= presc_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      led_q    <= led_d;
    end
  end

  assign o_led  = led_q;
  assign o_duty = duty_q;
  assign o_busy = (state_q != ST_IDLE);

endmodule
`default_nettype wire
